// File: rtl/dma_pkg.sv
// Shared definitions for the DMA initiator: FSM state type, bus address width
// and the fixed word addresses of the memory map.
package dma_pkg;

   localparam int ADDR_W = 14;

   localparam logic [ADDR_W-1:0] RAM_BASE = 14'h400;
   localparam logic [ADDR_W-1:0] RAM_LAST = 14'h4FF;
   localparam logic [ADDR_W-1:0] LED_ADDR = 14'h801;
   localparam logic [ADDR_W-1:0] SEG_ADDR = 14'h802;
   localparam logic [ADDR_W-1:0] TMP_DATA = 14'h80D;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_RD   = 3'd2,
      ST_CAP  = 3'd3,
      ST_WR   = 3'd4,
      ST_FIN  = 3'd5
   } state_e;

endpackage

// File: rtl/dma_addr_ctr.sv
// Loadable word-address counter; increments wrap naturally modulo 2^ADDR_W.
module dma_addr_ctr
   import dma_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              load_i,
   input  logic              inc_i,
   input  logic [ADDR_W-1:0] load_val_i,
   output logic [ADDR_W-1:0] addr_o
);

   logic [ADDR_W-1:0] addr_d;
   logic [ADDR_W-1:0] addr_q;

   always_comb begin
      addr_d = addr_q;
      if (load_i) begin
         addr_d = load_val_i;
      end else if (inc_i) begin
         addr_d = addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/dma_initiator.sv
// Word-copy DMA initiator: reads one word, captures it, writes it, repeating
// for len words while the shared bus is granted; stalls in place without grant.
module dma_initiator
   import dma_pkg::*;
#(
   parameter int LEN_W = 9
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] src_i,
   input  logic [ADDR_W-1:0] dst_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              bus_req_o,
   input  logic              bus_gnt_i,
   output logic [ADDR_W-1:0] addr_byte_o,
   output logic              we_o,
   output logic [31:0]       wdata_o,
   input  logic [31:0]       rdata_i,
   output logic              busy_o,
   output logic              done_o
);

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        data_q, data_d;
   logic               load;
   logic               adv;
   logic [ADDR_W-1:0]  cur_src;
   logic [ADDR_W-1:0]  cur_dst;

   dma_addr_ctr u_src_ctr (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (load),
      .inc_i      (adv),
      .load_val_i (src_i),
      .addr_o     (cur_src)
   );

   dma_addr_ctr u_dst_ctr (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (load),
      .inc_i      (adv),
      .load_val_i (dst_i),
      .addr_o     (cur_dst)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      load        = 1'b0;
      adv         = 1'b0;
      bus_req_o   = 1'b0;
      addr_byte_o = '0;
      we_o        = 1'b0;
      wdata_o     = '0;
      busy_o      = 1'b1;
      done_o      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               load    = 1'b1;
               cnt_d   = len_i;
               state_d = (len_i == '0) ? ST_FIN : ST_REQ;
            end
         end
         ST_REQ: begin
            bus_req_o = 1'b1;
            if (bus_gnt_i) begin
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            bus_req_o = 1'b1;
            if (bus_gnt_i) begin
               addr_byte_o = cur_src;
               state_d     = ST_CAP;
            end
         end
         // rdata_i is re-sampled whenever capture completes, so a stall here
         // relies on the decoder holding the last read word.
         ST_CAP: begin
            bus_req_o = 1'b1;
            if (bus_gnt_i) begin
               data_d  = rdata_i;
               state_d = ST_WR;
            end
         end
         ST_WR: begin
            bus_req_o = 1'b1;
            wdata_o   = data_q;
            if (bus_gnt_i) begin
               addr_byte_o = cur_dst;
               we_o        = 1'b1;
               adv         = 1'b1;
               cnt_d       = cnt_q - LEN_W'(1);
               state_d     = (cnt_q == LEN_W'(1)) ? ST_FIN : ST_RD;
            end
         end
         ST_FIN: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_dma_initiator.sv
// Self-checking bench for dma_initiator: a bus memory, a step-count reference
// model of the copy sequence, randomized grants and directed corner cases.
module tb_dma_initiator;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [13:0] src;
   logic [13:0] dst;
   logic [8:0]  len;
   logic        bus_req;
   logic        bus_gnt;
   logic [13:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;

   dma_initiator #(.LEN_W(9)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .start_i     (start),
      .src_i       (src),
      .dst_i       (dst),
      .len_i       (len),
      .bus_req_o   (bus_req),
      .bus_gnt_i   (bus_gnt),
      .addr_byte_o (addr),
      .we_o        (we),
      .wdata_o     (wdata),
      .rdata_i     (rdata),
      .busy_o      (busy),
      .done_o      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] bus_mem [0:16383];
   logic [31:0] ref_mem [0:16383];
   bit          rd_strobe;
   bit          mem_wr_en;
   logic [13:0] mem_wr_addr;
   logic [31:0] mem_wr_data;

   int n_chk;
   int n_fail;

   logic [13:0] rd_log [$];
   logic [13:0] wr_log [$];
   bit          req_seen;

   // Bus memory: the decoder returns read data one cycle after a read address
   // and holds it until the next read.
   always @(posedge clk) begin
      if (mem_wr_en) bus_mem[mem_wr_addr] = mem_wr_data;
      else if (we) bus_mem[addr] = wdata;
      if (rd_strobe) rdata <= bus_mem[addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic preload(input logic [13:0] a, input logic [31:0] v);
      @(negedge clk);
      mem_wr_en = 1'b1; mem_wr_addr = a; mem_wr_data = v;
      ref_mem[a] = v;
      @(posedge clk); #1;
      mem_wr_en = 1'b0;
   endtask

   // One transfer from start to done, checked every cycle against the model.
   // The model tracks how many granted steps have been consumed: step 0 is the
   // bus request, then three steps (read, capture, write) per word, then done.
   task automatic run_xfer(input logic [13:0] s, input logic [13:0] d, input int l,
                           input int mode, output int done_cyc, output int n_we);
      int          step, last, cyc, k, sub;
      bit          g, fin;
      logic [31:0] pend, cap_data;
      logic [13:0] ak;
      bit          e_req, e_busy, e_done, e_we;
      logic [13:0] e_addr;
      logic [31:0] e_wd;

      rd_log.delete(); wr_log.delete(); req_seen = 0;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      start = 1'b1; src = s; dst = d; len = 9'(l);
      @(posedge clk); #1;
      start = 1'b0; src = 14'($urandom); dst = 14'($urandom); len = 9'($urandom);
      last = 3 * l + 1;
      step = (l == 0) ? last : 0;
      cyc = 1; done_cyc = -1; n_we = 0; fin = 0;
      pend = '0; cap_data = '0;
      while (!fin && cyc < 3 * l + 400) begin
         case (mode)
            0:       g = 1'b1;
            1:       g = ($urandom_range(0, 3) != 0);
            default: g = !(cyc inside {3, 4, 5, 7, 8, 9});
         endcase
         bus_gnt = g;
         start = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         e_req = 0; e_busy = 1; e_done = 0; e_we = 0; e_addr = '0; e_wd = '0;
         rd_strobe = 0;
         if (step == last) begin
            e_done = 1; fin = 1; done_cyc = cyc;
         end else begin
            e_req = 1;
            if (step > 0) begin
               k   = (step - 1) / 3;
               sub = (step - 1) % 3;
               if (sub == 2) e_wd = cap_data;
               if (g) begin
                  if (sub == 0) begin
                     ak = s + 14'(k);
                     e_addr = ak; rd_strobe = 1; pend = ref_mem[ak];
                     rd_log.push_back(addr);
                  end else if (sub == 1) begin
                     cap_data = pend;
                  end else begin
                     ak = d + 14'(k);
                     e_addr = ak; e_we = 1; ref_mem[ak] = cap_data;
                  end
               end
            end
            if (g) step++;
         end
         if (bus_req) req_seen = 1;
         if (we) begin n_we++; wr_log.push_back(addr); end
         chk("bus_req", {31'd0, bus_req}, {31'd0, e_req});
         chk("busy",    {31'd0, busy},    {31'd0, e_busy});
         chk("done",    {31'd0, done},    {31'd0, e_done});
         chk("we",      {31'd0, we},      {31'd0, e_we});
         chk("addr",    {18'd0, addr},    {18'd0, e_addr});
         chk("wdata",   wdata,            e_wd);
         @(posedge clk); #1;
         rd_strobe = 0;
         if (!fin) cyc++;
      end
      start = 1'b0;
      bus_gnt = 1'b1;
      if (!fin) chk("done_timeout", 32'd0, 32'd1);
   endtask

   int dc, nw;
   logic [13:0] rs, rd;
   int rl;

   initial begin
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0; bus_gnt = 1'b1;
      rd_strobe = 0; mem_wr_en = 0; mem_wr_addr = '0; mem_wr_data = '0; rdata = '0;
      for (int i = 0; i < 16384; i++) begin
         logic [31:0] w;
         w = $urandom;
         bus_mem[i] = w;
         ref_mem[i] = w;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_busy",    {31'd0, busy},    32'd0);
      chk("rst_done",    {31'd0, done},    32'd0);
      chk("rst_we",      {31'd0, we},      32'd0);
      chk("rst_addr",    {18'd0, addr},    32'd0);
      chk("rst_wdata",   wdata,            32'd0);
      rst_n = 1'b1;

      // single word to the LED register
      preload(14'h400, 32'hDEADBEEF);
      run_xfer(14'h400, 14'h801, 1, 0, dc, nw);
      chk("t1_done_cyc", 32'(dc), 32'd5);
      chk("t1_n_we", 32'(nw), 32'd1);
      chk("t1_rd_addr", {18'd0, rd_log[0]}, 32'h400);
      chk("t1_wr_addr", {18'd0, wr_log[0]}, 32'h801);
      chk("t1_mem", bus_mem[14'h801], 32'hDEADBEEF);

      // four-word block copy
      for (int i = 0; i < 4; i++) preload(14'h400 + 14'(i), 32'(i + 1));
      run_xfer(14'h400, 14'h480, 4, 0, dc, nw);
      chk("t2_done_cyc", 32'(dc), 32'd14);
      chk("t2_n_we", 32'(nw), 32'd4);
      for (int i = 0; i < 4; i++) chk("t2_mem", bus_mem[14'h480 + 14'(i)], 32'(i + 1));

      // zero length
      run_xfer(14'h123, 14'h456, 0, 0, dc, nw);
      chk("t3_done_cyc", 32'(dc), 32'd1);
      chk("t3_n_we", 32'(nw), 32'd0);
      chk("t3_req_seen", {31'd0, req_seen}, 32'd0);

      // address wrap
      preload(14'h3FFF, 32'hA5A50001);
      preload(14'h0000, 32'h5A5A0002);
      run_xfer(14'h3FFF, 14'h4FE, 2, 0, dc, nw);
      chk("t4_rd0", {18'd0, rd_log[0]}, 32'h3FFF);
      chk("t4_rd1", {18'd0, rd_log[1]}, 32'h0000);
      chk("t4_wr0", {18'd0, wr_log[0]}, 32'h4FE);
      chk("t4_wr1", {18'd0, wr_log[1]}, 32'h4FF);
      chk("t4_mem0", bus_mem[14'h4FE], 32'hA5A50001);
      chk("t4_mem1", bus_mem[14'h4FF], 32'h5A5A0002);

      // grant dropped 3 cycles in capture and 3 cycles in write
      preload(14'h410, 32'h12345678);
      run_xfer(14'h410, 14'h420, 1, 2, dc, nw);
      chk("t5_done_cyc", 32'(dc), 32'd11);
      chk("t5_n_we", 32'(nw), 32'd1);
      chk("t5_mem", bus_mem[14'h420], 32'h12345678);

      // reset asserted while in the write state
      @(negedge clk);
      start = 1'b1; src = 14'h430; dst = 14'h440; len = 9'd4; bus_gnt = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("t6_in_wr_we", {31'd0, we}, 32'd1);
      chk("t6_in_wr_addr", {18'd0, addr}, 32'h440);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_we",      {31'd0, we},      32'd0);
      chk("t6_rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("t6_rst_busy",    {31'd0, busy},    32'd0);
      chk("t6_rst_addr",    {18'd0, addr},    32'd0);
      chk("t6_rst_wdata",   wdata,            32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("t6_rst_done", {31'd0, done}, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_xfer(14'h430, 14'h440, 4, 0, dc, nw);
      chk("t6_done_cyc", 32'(dc), 32'd14);
      chk("t6_n_we", 32'(nw), 32'd4);

      // full 256-word window
      run_xfer(14'h400, 14'h1000, 256, 0, dc, nw);
      chk("t7_done_cyc", 32'(dc), 32'd770);
      chk("t7_n_we", 32'(nw), 32'd256);

      // randomized transfers, random grant, overlapping ranges included
      for (int t = 0; t < 14; t++) begin
         rs = 14'($urandom);
         rd = (t % 3 == 0) ? rs + 14'($urandom_range(0, 3)) : 14'($urandom);
         rl = $urandom_range(0, 24);
         run_xfer(rs, rd, rl, 1, dc, nw);
         chk("rnd_n_we", 32'(nw), 32'(rl));
      end

      for (int i = 0; i < 16384; i++) begin
         if (bus_mem[i] !== ref_mem[i]) chk("final_mem", bus_mem[i], ref_mem[i]);
      end
      n_chk++;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
